// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and a helper that classifies the multi-cycle operations.
package univ_shift_reg_pkg;

   localparam logic [2:0] OPC_NOP  = 3'd0;
   localparam logic [2:0] OPC_LOAD = 3'd1;
   localparam logic [2:0] OPC_SHL  = 3'd2;
   localparam logic [2:0] OPC_SHR  = 3'd3;
   localparam logic [2:0] OPC_ROL  = 3'd4;
   localparam logic [2:0] OPC_ROR  = 3'd5;
   localparam logic [2:0] OPC_ASR  = 3'd6;
   localparam logic [2:0] OPC_RSVD = 3'd7;

   typedef enum logic [2:0] {
      OP_NOP  = OPC_NOP,
      OP_LOAD = OPC_LOAD,
      OP_SHL  = OPC_SHL,
      OP_SHR  = OPC_SHR,
      OP_ROL  = OPC_ROL,
      OP_ROR  = OPC_ROR,
      OP_ASR  = OPC_ASR,
      OP_RSVD = OPC_RSVD
   } shift_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // True for the operations that step the register one bit per cycle.
   function automatic logic is_shift_op(input shift_op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational single-bit step of the shift register: produces the next
// register value and the bit that leaves the register for the given op.
module shift_step
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  shift_op_e        op,
   input  logic [WIDTH-1:0] q,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q_next,
   output logic             bit_out
);

   // One-bit move in the direction the op selects.
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      q_next  = q;
      bit_out = 1'b0;
      case (op)
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], ser_in};
            bit_out = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {ser_in, q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            bit_out = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ASR: begin
            q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift, rotate and arithmetic
// shift-right by a multi-bit amount, one bit per cycle, behind a valid/ready
// command handshake. Optional abort of a running shift is enabled by defining
// UNIV_SHIFT_REG_ABORT_EN.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int  WIDTH = 16,
   localparam int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
`ifdef UNIV_SHIFT_REG_ABORT_EN
   ,
   input  logic             abort,
   output logic             aborted
`endif
);

   state_e           state_q;
   shift_op_e        op_q;
   logic [WIDTH-1:0] q_q;
   logic             ser_q;
   logic             done_q;
   logic [AMT_W-1:0] cnt_q;
`ifdef UNIV_SHIFT_REG_ABORT_EN
   logic             aborted_q;
`endif

   shift_op_e        cmd_op_e;
   logic             accept;
   logic [AMT_W-1:0] amt_clamped;
   logic [WIDTH-1:0] q_step;
   logic             bit_step;

   assign cmd_op_e  = shift_op_e'(cmd_op);
   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Amounts beyond the register width behave as a full-width shift.
   always_comb begin
      amt_clamped = cmd_amt;
      if (cmd_amt > AMT_W'(WIDTH)) amt_clamped = AMT_W'(WIDTH);
   end

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op      (op_q),
      .q       (q_q),
      .ser_in  (ser_in),
      .q_next  (q_step),
      .bit_out (bit_step)
   );

   // Command FSM and datapath: accept in IDLE, step once per cycle in SHIFT.
   always_ff @(posedge clk) begin
      // NOTE: synchronous reset inside the clocked block; all state uses <= so
      // every register sees the values from before this edge.
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_NOP;
         q_q       <= '0;
         ser_q     <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef UNIV_SHIFT_REG_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
`ifdef UNIV_SHIFT_REG_ABORT_EN
         aborted_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_shift_op(cmd_op_e) && (cmd_amt != '0)) begin
                     op_q    <= cmd_op_e;
                     cnt_q   <= amt_clamped;
                     state_q <= SHIFT;
                  end else begin
                     // LOAD, NOP, reserved and zero-length shifts finish at once.
                     if (cmd_op_e == OP_LOAD) q_q <= load_data;
                     done_q <= 1'b1;
                  end
               end
            end
            SHIFT: begin
`ifdef UNIV_SHIFT_REG_ABORT_EN
               if (abort) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  aborted_q <= 1'b1;
               end else
`endif
               begin
                  q_q   <= q_step;
                  ser_q <= bit_step;
                  cnt_q <= cnt_q - AMT_W'(1);
                  if (cnt_q == AMT_W'(1)) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign q_out   = q_q;
   assign ser_out = ser_q;
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;
`ifdef UNIV_SHIFT_REG_ABORT_EN
   assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=16). Command vectors come from
// a table; final register/serial values are queued when a command is issued and
// compared when the DUT pulses done.
module tb_univ_shift_reg;

   localparam int WIDTH = 16;
   localparam int AMT_W = 5;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [WIDTH-1:0] load_data;
   logic             ser_in;
   logic [WIDTH-1:0] q_out;
   logic             ser_out;
   logic             busy;
   logic             done;
`ifdef UNIV_SHIFT_REG_ABORT_EN
   logic             abort;
   logic             aborted;
`endif

   univ_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .load_data (load_data),
      .ser_in    (ser_in),
      .q_out     (q_out),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done)
`ifdef UNIV_SHIFT_REG_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       op;
      logic [AMT_W-1:0] amt;
      logic [WIDTH-1:0] data;
      logic             sin;
      logic [WIDTH-1:0] exp_q;
      logic             exp_ser;
      int               exp_busy;
   } vec_t;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic             ser;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding command.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: done=1 with no command outstanding at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_q_out", 32'(q_out), 32'(e.q));
            check("sb_ser_out", 32'(ser_out), 32'(e.ser));
         end
      end
   end

   // Issue one command and follow it to done, checking timing and status.
   task automatic run_cmd(input vec_t v, input int idx);
      int busy_cnt;
      int lat;
      bit got;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_amt   = v.amt;
      load_data = v.data;
      ser_in    = v.sin;
      check($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
      sb_q.push_back('{q: v.exp_q, ser: v.exp_ser});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      busy_cnt = 0;
      lat      = 1;
      got      = 1'b0;
      while (!got && lat <= 40) begin
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (busy === 1'b1) busy_cnt++;
            lat++;
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL v%0d_timeout: no done within 40 cycles", idx);
      end else begin
         check($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.exp_busy));
         check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_busy + 1));
         check($sformatf("v%0d_busy_at_done", idx), 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", idx), 32'(done), 32'd0);
   endtask

   vec_t vecs[16];

   initial begin
      int busy_cnt;
      int ready_hi;
      int lat;
      bit got;

      // op, amt, load_data, ser_in, exp q_out, exp ser_out, busy cycles
      vecs[0]  = '{3'd1, 5'd0,  16'hA5C3, 1'b0, 16'hA5C3, 1'b0, 0};
      vecs[1]  = '{3'd4, 5'd4,  16'h0000, 1'b0, 16'h5C3A, 1'b0, 4};
      vecs[2]  = '{3'd1, 5'd0,  16'h8001, 1'b0, 16'h8001, 1'b0, 0};
      vecs[3]  = '{3'd6, 5'd3,  16'h0000, 1'b1, 16'hF000, 1'b0, 3};
      vecs[4]  = '{3'd1, 5'd0,  16'h0001, 1'b0, 16'h0001, 1'b0, 0};
      vecs[5]  = '{3'd3, 5'd1,  16'h0000, 1'b0, 16'h0000, 1'b1, 1};
      vecs[6]  = '{3'd0, 5'd7,  16'h1234, 1'b1, 16'h0000, 1'b1, 0};
      vecs[7]  = '{3'd2, 5'd0,  16'h1234, 1'b1, 16'h0000, 1'b1, 0};
      vecs[8]  = '{3'd7, 5'd5,  16'h1234, 1'b1, 16'h0000, 1'b1, 0};
      vecs[9]  = '{3'd1, 5'd0,  16'h8000, 1'b0, 16'h8000, 1'b1, 0};
      vecs[10] = '{3'd5, 5'd16, 16'h0000, 1'b0, 16'h8000, 1'b1, 16};
      vecs[11] = '{3'd4, 5'd17, 16'h0000, 1'b0, 16'h8000, 1'b0, 16};
      vecs[12] = '{3'd2, 5'd3,  16'h0000, 1'b1, 16'h0007, 1'b0, 3};
      vecs[13] = '{3'd1, 5'd0,  16'h4000, 1'b0, 16'h4000, 1'b0, 0};
      vecs[14] = '{3'd6, 5'd2,  16'h0000, 1'b1, 16'h1000, 1'b0, 2};
      vecs[15] = '{3'd5, 5'd31, 16'h0000, 1'b0, 16'h1000, 1'b0, 16};

      // Reset with random inputs on the command interface.
      rst       = 1'b1;
      cmd_valid = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_amt   = 5'($urandom);
      load_data = 16'($urandom);
      ser_in    = 1'($urandom);
`ifdef UNIV_SHIFT_REG_ABORT_EN
      abort     = 1'($urandom);
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_q_out", 32'(q_out), 32'h0);
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
`ifdef UNIV_SHIFT_REG_ABORT_EN
      check("rst_aborted", 32'(aborted), 32'd0);
      abort = 1'b0;
`endif
      rst       = 1'b0;
      cmd_valid = 1'b0;
      ser_in    = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) run_cmd(vecs[i], i);

      // Clamped SHL with a pending command held on the interface.
      run_cmd('{3'd1, 5'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0}, 100);
      cmd_valid = 1'b1;
      cmd_op    = 3'd2;
      cmd_amt   = 5'd20;
      ser_in    = 1'b1;
      check("shl20_ready", 32'(cmd_ready), 32'd1);
      sb_q.push_back('{q: 16'hFFFF, ser: 1'b0});
      @(posedge clk); #1;
      cmd_op   = 3'd3;
      cmd_amt  = 5'd8;
      busy_cnt = 0;
      ready_hi = 0;
      lat      = 1;
      got      = 1'b0;
      while (!got && lat <= 40) begin
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (busy === 1'b1) busy_cnt++;
            if (cmd_ready !== 1'b0) ready_hi++;
            lat++;
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL shl20_timeout: no done within 40 cycles");
      end
      check("shl20_busy_cycles", 32'(busy_cnt), 32'd16);
      check("shl20_ready_while_busy", 32'(ready_hi), 32'd0);
      check("shl20_ready_at_done", 32'(cmd_ready), 32'd1);
      ser_in = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("b2b_accepted_busy", 32'(busy), 32'd1);
      check("b2b_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("shr8_busy2", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_q_out", 32'(q_out), 32'h0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_ser_out", 32'(ser_out), 32'd0);
      @(posedge clk); #1;
      check("midrst_no_late_done", 32'(done), 32'd0);

`ifdef UNIV_SHIFT_REG_ABORT_EN
      // Abort a running SHR on its third busy cycle.
      run_cmd('{3'd1, 5'd0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 0}, 200);
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      cmd_amt   = 5'd8;
      ser_in    = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("ab_busy1", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("ab_busy2", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("ab_busy3", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("ab_q_out", 32'(q_out), 32'h3FFF);
      check("ab_ser_out", 32'(ser_out), 32'd1);
      check("ab_aborted", 32'(aborted), 32'd1);
      check("ab_done", 32'(done), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("ab_aborted_pulse", 32'(aborted), 32'd0);
      check("ab_no_done", 32'(done), 32'd0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("ab_idle_q_out", 32'(q_out), 32'h3FFF);
      check("ab_idle_aborted", 32'(aborted), 32'd0);
`endif

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
